// File: rtl/dpwm_comparador_if.sv
// ============================================================================
// Module      : dpwm_comparador_if
// Description : Ramp/duty bus between the DPWM ramp side and the comparator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dpwm_comparador_if #(
    parameter int CNT_W = 10
);
    logic [CNT_W-1:0] cuenta10;
    logic [CNT_W-1:0] duty_in;
    logic             duty_valid;
    logic             duty_ready;
    logic [CNT_W-1:0] duty_active;
    logic             duty_clamped;
    logic             period_start;
    logic             pwm_hi;
    logic             pwm_lo;

    modport master (
        output cuenta10, duty_in, duty_valid,
        input  duty_ready, duty_active, duty_clamped, period_start, pwm_hi, pwm_lo
    );

    modport slave (
        input  cuenta10, duty_in, duty_valid,
        output duty_ready, duty_active, duty_clamped, period_start, pwm_hi, pwm_lo
    );
endinterface

`default_nettype wire

// File: rtl/dpwm_comparador.sv
// ============================================================================
// Module      : dpwm_comparador
// Description : Double-buffered duty compare against the ramp count, driving a
//               complementary gate pair with dead-time insertion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpwm_comparador #(
    parameter int CNT_W      = 10,
    parameter int PERIOD_MAX = 1000,
    parameter int DT_CYC     = 2
) (
    input  logic                 clkFC,
    input  logic                 reset,
    dpwm_comparador_if.slave     bus
);

    localparam int               DT_W   = (DT_CYC > 1) ? $clog2(DT_CYC) : 1;
    localparam logic [DT_W-1:0]  DT_LOAD = DT_W'((DT_CYC > 0) ? DT_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] C_MAX   = CNT_W'(PERIOD_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEAD  = 2'd1,
        HI_ON = 2'd2,
        LO_ON = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             target_q, target_d;
    logic [DT_W-1:0]  dt_cnt_q, dt_cnt_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             pend_full_q, pend_full_d;
    logic [CNT_W-1:0] duty_active_q, duty_active_d;
    logic             duty_clamped_q, duty_clamped_d;
    logic             period_start_q, period_start_d;
    logic             pwm_hi_q, pwm_hi_d;
    logic             pwm_lo_q, pwm_lo_d;

    logic accept;
    logic bound;
    logic over;
    logic raw;

    assign accept = bus.duty_valid && !pend_full_q;
    assign bound  = (bus.cuenta10 == '0);
    assign over   = (bus.duty_in > C_MAX);
    // Full-scale duty forces the high side on even at the wrap sample.
    assign raw    = (duty_active_q == C_MAX) ? 1'b1 : (bus.cuenta10 < duty_active_q);

    always_comb begin
        pending_d      = pending_q;
        pend_full_d    = pend_full_q;
        duty_active_d  = duty_active_q;
        duty_clamped_d = accept && over;
        period_start_d = bound;
        if (bound && pend_full_q) begin
            duty_active_d = pending_q;
            pend_full_d   = 1'b0;
        end
        if (accept) begin
            pending_d   = over ? C_MAX : bus.duty_in;
            pend_full_d = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dt_cnt_d = dt_cnt_q;
        case (state_q)
            IDLE: begin
                if (DT_CYC == 0) begin
                    state_d = raw ? HI_ON : LO_ON;
                end else begin
                    state_d  = DEAD;
                    target_d = raw;
                    dt_cnt_d = DT_LOAD;
                end
            end
            HI_ON: begin
                if (!raw) begin
                    if (DT_CYC == 0) begin
                        state_d = LO_ON;
                    end else begin
                        state_d  = DEAD;
                        target_d = 1'b0;
                        dt_cnt_d = DT_LOAD;
                    end
                end
            end
            LO_ON: begin
                if (raw) begin
                    if (DT_CYC == 0) begin
                        state_d = HI_ON;
                    end else begin
                        state_d  = DEAD;
                        target_d = 1'b1;
                        dt_cnt_d = DT_LOAD;
                    end
                end
            end
            DEAD: begin
                // A pulse that reverses during dead time restarts it, swallowing the pulse.
                if (raw != target_q) begin
                    target_d = raw;
                    dt_cnt_d = DT_LOAD;
                end else if (dt_cnt_q == '0) begin
                    state_d = target_q ? HI_ON : LO_ON;
                end else begin
                    dt_cnt_d = dt_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        pwm_hi_d = (state_d == HI_ON);
        pwm_lo_d = (state_d == LO_ON);
    end

    always_ff @(posedge clkFC or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            target_q       <= 1'b0;
            dt_cnt_q       <= '0;
            pending_q      <= '0;
            pend_full_q    <= 1'b0;
            duty_active_q  <= '0;
            duty_clamped_q <= 1'b0;
            period_start_q <= 1'b0;
            pwm_hi_q       <= 1'b0;
            pwm_lo_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            dt_cnt_q       <= dt_cnt_d;
            pending_q      <= pending_d;
            pend_full_q    <= pend_full_d;
            duty_active_q  <= duty_active_d;
            duty_clamped_q <= duty_clamped_d;
            period_start_q <= period_start_d;
            pwm_hi_q       <= pwm_hi_d;
            pwm_lo_q       <= pwm_lo_d;
        end
    end

    assign bus.duty_ready   = !pend_full_q;
    assign bus.duty_active  = duty_active_q;
    assign bus.duty_clamped = duty_clamped_q;
    assign bus.period_start = period_start_q;
    assign bus.pwm_hi       = pwm_hi_q;
    assign bus.pwm_lo       = pwm_lo_q;

endmodule

`default_nettype wire
